// File: rtl/vga_pkg.sv
// Purpose : shared 640x480@60 timing defaults and 24-bit colour constants.
// Latency : n/a (constants only).
// Backpressure : none.
package vga_pkg;

  // Default 640x480@60 raster timing (pixel clock ~25.175 MHz)
  localparam int H_ACTIVE_D   = 640;
  localparam int H_FP_D       = 16;
  localparam int H_SYNC_D     = 96;
  localparam int H_BP_D       = 48;
  localparam int V_ACTIVE_D   = 480;
  localparam int V_FP_D       = 10;
  localparam int V_SYNC_D     = 2;
  localparam int V_BP_D       = 33;
  localparam int UPDATE_DIV_D = 6;
  localparam int BORDER_D     = 10;

  localparam int H_TOTAL = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;  // 800
  localparam int V_TOTAL = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;  // 525

  // {R, G, B}
  localparam logic [23:0] COL_HEAD   = 24'hFFFF00;
  localparam logic [23:0] COL_BODY   = 24'h00FF00;
  localparam logic [23:0] COL_BORDER = 24'hFFFFFF;
  localparam logic [23:0] COL_IDLE   = 24'h0000C0;
  localparam logic [23:0] COL_BLACK  = 24'h000000;

endpackage

// File: rtl/vga_raster_counter.sv
// Purpose : x/y raster counters with raw sync, active-area and vblank-start decode.
// Latency : counters registered; all decodes combinational from the counters.
// Backpressure : none, free-running every pixel clock.
//
// Ports:
//   clk_i, reset_i           pixel clock, synchronous active-high reset
//   x_o, y_o                 current raster position
//   hs_raw_o, vs_raw_o       active-low syncs decoded from x_o/y_o
//   display_o                x_o/y_o inside the visible area
//   vblank_start_o           high on the last pixel of the last visible line,
//                            i.e. the next edge enters vertical blanking
module vga_raster_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       hs_raw_o,
  output logic       vs_raw_o,
  output logic       display_o,
  output logic       vblank_start_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M1  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       x_last;

  always_comb begin
    x_last = (x_q == H_LAST);
    x_d    = x_last ? 10'd0 : x_q + 10'd1;
    y_d    = y_q;
    if (x_last) begin
      y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q <= 10'd0;
      y_q <= 10'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o            = x_q;
  assign y_o            = y_q;
  assign hs_raw_o       = !((x_q >= HS_START) && (x_q < HS_END));
  assign vs_raw_o       = !((y_q >= VS_START) && (y_q < VS_END));
  assign display_o      = (x_q < H_ACT) && (y_q < V_ACT);
  assign vblank_start_o = x_last && (y_q == V_ACT_M1);

endmodule

// File: rtl/vga_frame_gen.sv
// Purpose : VGA raster timing, frame-rate game tick and snake colour output.
// Latency : counter value at cycle t shows on sync/blank/RGB at cycle t+2.
// Backpressure : none; the snake flags must arrive one cycle after xCount/yCount.
//
// Ports:
//   VGA_clk, reset           pixel clock, synchronous active-high reset
//   start                    1 = game colours, 0 = idle blue screen
//   snakeHead, snakeBody     pixel flags for the position driven one cycle earlier
//   xCount, yCount           raster position to the snake logic
//   displayArea              combinational visible-area flag for xCount/yCount
//   update                   one-cycle tick every UPDATE_DIV frames at vblank start
//   VGA_hSync, VGA_vSync     active-low syncs, aligned with RGB
//   blank_n                  high during visible pixels, aligned with RGB
//   VGA_R, VGA_G, VGA_B      8-bit colour channels
module vga_frame_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_D,
  parameter int H_FP       = H_FP_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BP       = H_BP_D,
  parameter int V_ACTIVE   = V_ACTIVE_D,
  parameter int V_FP       = V_FP_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BP       = V_BP_D,
  parameter int UPDATE_DIV = UPDATE_DIV_D,
  parameter int BORDER     = BORDER_D
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       snakeHead,
  input  logic       snakeBody,
  output logic [9:0] xCount,
  output logic [9:0] yCount,
  output logic       displayArea,
  output logic       update,
  output logic       VGA_hSync,
  output logic       VGA_vSync,
  output logic       blank_n,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int FDIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [FDIV_W-1:0] FDIV_LAST = FDIV_W'(UPDATE_DIV - 1);

  localparam logic [9:0] BRD_LO_X = 10'(BORDER);
  localparam logic [9:0] BRD_HI_X = 10'(H_ACTIVE - BORDER);
  localparam logic [9:0] BRD_LO_Y = 10'(BORDER);
  localparam logic [9:0] BRD_HI_Y = 10'(V_ACTIVE - BORDER);

  logic hs_raw, vs_raw, vblank_start, border;

  vga_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_raster (
    .clk_i          (VGA_clk),
    .reset_i        (reset),
    .x_o            (xCount),
    .y_o            (yCount),
    .hs_raw_o       (hs_raw),
    .vs_raw_o       (vs_raw),
    .display_o      (displayArea),
    .vblank_start_o (vblank_start)
  );

  assign border = displayArea &&
                  ((xCount < BRD_LO_X) || (xCount >= BRD_HI_X) ||
                   (yCount < BRD_LO_Y) || (yCount >= BRD_HI_Y));

  // Frame divider: counts vblank starts, independent of start so the snake
  // logic can keep reloading positions on the idle screen.
  logic [FDIV_W-1:0] fdiv_q, fdiv_d;
  logic              update_q, update_d;

  always_comb begin
    fdiv_d   = fdiv_q;
    update_d = 1'b0;
    if (vblank_start) begin
      if (fdiv_q == FDIV_LAST) begin
        fdiv_d   = '0;
        update_d = 1'b1;
      end else begin
        fdiv_d = fdiv_q + 1'b1;
      end
    end
  end

  // Stage 1 lines up with the snake flags, which are registered from the
  // same counter value in the snake logic.
  logic        hs1_q, vs1_q, de1_q, brd1_q;
  logic        hs2_q, vs2_q, de2_q;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = COL_BLACK;
    if (de1_q) begin
      if (!start)         rgb_d = COL_IDLE;
      else if (snakeHead) rgb_d = COL_HEAD;
      else if (snakeBody) rgb_d = COL_BODY;
      else if (brd1_q)    rgb_d = COL_BORDER;
    end
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      fdiv_q   <= '0;
      update_q <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      de1_q    <= 1'b0;
      brd1_q   <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      de2_q    <= 1'b0;
      rgb_q    <= COL_BLACK;
    end else begin
      fdiv_q   <= fdiv_d;
      update_q <= update_d;
      hs1_q    <= hs_raw;
      vs1_q    <= vs_raw;
      de1_q    <= displayArea;
      brd1_q   <= border;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      de2_q    <= de1_q;
      rgb_q    <= rgb_d;
    end
  end

  assign update    = update_q;
  assign VGA_hSync = hs2_q;
  assign VGA_vSync = vs2_q;
  assign blank_n   = de2_q;
  assign VGA_R     = rgb_q[23:16];
  assign VGA_G     = rgb_q[15:8];
  assign VGA_B     = rgb_q[7:0];

endmodule

// File: tb/tb_vga_frame_gen.sv
// Purpose : randomized check of vga_frame_gen against a frame-position model.
// Latency : model predicts outputs from the cycle count since reset.
// Backpressure : n/a.
module tb_vga_frame_gen;

  // Shrunk raster so several update periods fit in a short run
  localparam int HA = 40, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
  localparam int DIV = 3, BRD = 3;
  localparam int HT = HA + HFP + HS + HBP;   // 56
  localparam int VT = VA + VFP + VS + VBP;   // 37
  localparam int FRAME = HT * VT;            // 2072

  logic       VGA_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b1;
  logic       snakeHead = 1'b0;
  logic       snakeBody = 1'b0;
  logic [9:0] xCount, yCount;
  logic       displayArea, update, VGA_hSync, VGA_vSync, blank_n;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_frame_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .UPDATE_DIV (DIV), .BORDER (BRD)
  ) dut (
    .VGA_clk     (VGA_clk),
    .reset       (reset),
    .start       (start),
    .snakeHead   (snakeHead),
    .snakeBody   (snakeBody),
    .xCount      (xCount),
    .yCount      (yCount),
    .displayArea (displayArea),
    .update      (update),
    .VGA_hSync   (VGA_hSync),
    .VGA_vSync   (VGA_vSync),
    .blank_n     (blank_n),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  always #5 VGA_clk = ~VGA_clk;

  int errors = 0;
  int checks = 0;
  int t = 0;          // cycles since the last reset edge
  int ev = 0;         // vblank-start events since reset
  int seed_h, seed_b;
  bit allow_flip = 1'b1;
  int upd_seen = 0;
  int idle_upd_seen = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", name, t, obs, exp);
    end
  endtask

  // Reference snake: pseudo-random pixel sets keyed by position
  function automatic bit head_at(input int pos);
    int x, y;
    x = pos % HT;
    y = pos / HT;
    return ((x * 7 + y * 3 + seed_h) % 17) == 0;
  endfunction

  function automatic bit body_at(input int pos);
    int x, y;
    x = pos % HT;
    y = pos / HT;
    return ((x * 5 + y * 11 + seed_b) % 4) == 0;
  endfunction

  task automatic tick();
    bit rst_e, st;
    int p, q, qx, qy;
    bit act, brd, eh, ev_, eb, eupd;
    logic [23:0] ergb;
    @(posedge VGA_clk);
    #1;
    rst_e = reset;
    st    = start;
    if (rst_e) begin
      t  = 0;
      ev = 0;
    end else begin
      t++;
    end
    p = t % FRAME;

    eupd = 1'b0;
    if (!rst_e && p == VA * HT) begin
      ev++;
      eupd = (ev % DIV) == 0;
    end

    // Outputs at cycle t describe the raster position of cycle t-2
    eh = 1'b1; ev_ = 1'b1; eb = 1'b0; ergb = 24'h0;
    if (!rst_e && t >= 2) begin
      q   = (t - 2) % FRAME;
      qx  = q % HT;
      qy  = q / HT;
      act = (qx < HA) && (qy < VA);
      brd = act && (qx < BRD || qx >= HA - BRD || qy < BRD || qy >= VA - BRD);
      eh  = !(qx >= HA + HFP && qx < HA + HFP + HS);
      ev_ = !(qy >= VA + VFP && qy < VA + VFP + VS);
      eb  = act;
      if (act) begin
        if (!st)             ergb = 24'h0000C0;
        else if (head_at(q)) ergb = 24'hFFFF00;
        else if (body_at(q)) ergb = 24'h00FF00;
        else if (brd)        ergb = 24'hFFFFFF;
        else                 ergb = 24'h000000;
      end
    end

    check("xCount", {22'd0, xCount}, p % HT);
    check("yCount", {22'd0, yCount}, p / HT);
    check("displayArea", {31'd0, displayArea}, {31'd0, ((p % HT) < HA) && ((p / HT) < VA)});
    check("update", {31'd0, update}, {31'd0, eupd});
    check("hSync", {31'd0, VGA_hSync}, {31'd0, eh});
    check("vSync", {31'd0, VGA_vSync}, {31'd0, ev_});
    check("blank_n", {31'd0, blank_n}, {31'd0, eb});
    check("RGB", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, ergb});

    if (eupd) begin
      upd_seen++;
      if (!st) idle_upd_seen++;
    end

    // Snake flags for the previous cycle's position, like a registered lookup
    if (t >= 1) begin
      snakeHead = head_at((t - 1) % FRAME);
      snakeBody = body_at((t - 1) % FRAME);
    end else begin
      snakeHead = 1'b0;
      snakeBody = 1'b0;
    end
    if (allow_flip && $urandom_range(0, 299) == 0) start = ~start;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (errors > 20) break;
      tick();
    end
  endtask

  initial begin
    seed_h = int'($urandom_range(0, 16));
    seed_b = int'($urandom_range(0, 3));

    // Power-on reset, then a stretch of normal running with random start
    do_reset(5);
    run(3000);

    // Mid-frame reset for 5 cycles: everything returns to inactive values
    do_reset(5);
    run(7000);

    // Idle screen for a full divider period: update must still pulse
    allow_flip = 1'b0;
    start = 1'b0;
    run(DIV * FRAME + 200);

    // Game running again with random start toggles
    allow_flip = 1'b1;
    start = 1'b1;
    run(6000);

    checks++;
    assert (upd_seen >= 3) else begin
      errors++;
      $error("FAIL update_count observed=%0d expected>=3", upd_seen);
    end
    checks++;
    assert (idle_upd_seen >= 1) else begin
      errors++;
      $error("FAIL idle_update observed=%0d expected>=1", idle_upd_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
